// File: rtl/controller_pkg.sv
// ============================================================================
// Module   : controller_pkg
// Brief    : Shared encodings for the multicycle ARM control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_ORR = 3'b011;

  localparam logic [1:0] c_SRCA_REG = 2'b00;
  localparam logic [1:0] c_SRCA_PC  = 2'b01;

  localparam logic [1:0] c_SRCB_RM   = 2'b00;
  localparam logic [1:0] c_SRCB_IMM  = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR = 2'b10;

  localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] c_RES_DATA      = 2'b01;
  localparam logic [1:0] c_RES_ALURESULT = 2'b10;

  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_CMP = 4'b1010;
  localparam logic [3:0] c_CMD_AND = 4'b0000;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;
  localparam logic [3:0] c_CMD_MOV = 4'b1101;

  localparam logic [3:0] c_COND_EQ = 4'b0000;
  localparam logic [3:0] c_COND_NE = 4'b0001;
  localparam logic [3:0] c_COND_CS = 4'b0010;
  localparam logic [3:0] c_COND_CC = 4'b0011;
  localparam logic [3:0] c_COND_MI = 4'b0100;
  localparam logic [3:0] c_COND_PL = 4'b0101;
  localparam logic [3:0] c_COND_VS = 4'b0110;
  localparam logic [3:0] c_COND_VC = 4'b0111;
  localparam logic [3:0] c_COND_HI = 4'b1000;
  localparam logic [3:0] c_COND_LS = 4'b1001;
  localparam logic [3:0] c_COND_GE = 4'b1010;
  localparam logic [3:0] c_COND_LT = 4'b1011;
  localparam logic [3:0] c_COND_GT = 4'b1100;
  localparam logic [3:0] c_COND_LE = 4'b1101;
  localparam logic [3:0] c_COND_AL = 4'b1110;

  // flags are packed {N,Z,C,V}; the reserved 1111 condition never executes
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      c_COND_EQ: cond_holds = z;
      c_COND_NE: cond_holds = ~z;
      c_COND_CS: cond_holds = c;
      c_COND_CC: cond_holds = ~c;
      c_COND_MI: cond_holds = n;
      c_COND_PL: cond_holds = ~n;
      c_COND_VS: cond_holds = v;
      c_COND_VC: cond_holds = ~v;
      c_COND_HI: cond_holds = c & ~z;
      c_COND_LS: cond_holds = ~c | z;
      c_COND_GE: cond_holds = (n == v);
      c_COND_LT: cond_holds = (n != v);
      c_COND_GT: cond_holds = ~z & (n == v);
      c_COND_LE: cond_holds = z | (n != v);
      c_COND_AL: cond_holds = 1'b1;
      default:   cond_holds = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/controller_cond_unit.sv
// ============================================================================
// Module   : cond_unit
// Brief    : NZCV flags register, condition evaluation and flag-write gating.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cond_unit
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_exec,
  input  logic       i_s,
  input  logic [3:0] i_cmd,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;
  logic       w_cond_ex;
  logic       w_nz_en;
  logic       w_cv_en;

  assign w_cond_ex = cond_holds(i_cond, r_flags);
  assign o_cond_ex = w_cond_ex;

  // Unknown commands leave every flag alone; only arithmetic ops touch C and V.
  assign w_cv_en = (i_cmd == c_CMD_ADD) || (i_cmd == c_CMD_SUB) || (i_cmd == c_CMD_CMP);
  assign w_nz_en = w_cv_en || (i_cmd == c_CMD_AND) || (i_cmd == c_CMD_ORR) ||
                   (i_cmd == c_CMD_MOV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (i_exec && i_s && w_cond_ex && w_nz_en) begin
      r_flags[3:2] <= i_alu_flags[3:2];
      if (w_cv_en) begin
        r_flags[1:0] <= i_alu_flags[1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/controller.sv
// ============================================================================
// Module   : controller
// Brief    : Multicycle ARM control unit: main FSM, decode and write gating.
// Revision : 1.0
// ============================================================================
`default_nettype none

module controller
  import controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        isShift
);

  state_t     r_state;
  logic [1:0] w_op;
  logic       w_i;
  logic [3:0] w_cmd;
  logic       w_l;
  logic       w_rd_pc;
  logic       w_cond_ex;
  logic       w_exec;
  logic [2:0] w_exec_alu;
  logic       w_is_mov;
  logic       w_no_write;
  logic       w_pc_we;
  logic       w_reg_we;
  logic       w_mem_we;
  logic       w_ir_we;
  logic       w_unused;

  assign w_op     = Instr[27:26];
  assign w_i      = Instr[25];
  assign w_cmd    = Instr[24:21];
  assign w_l      = Instr[20];
  assign w_rd_pc  = (Instr[15:12] == 4'hF);
  assign w_exec   = (r_state == S_EXECR) || (r_state == S_EXECI);
  assign w_unused = ^{Instr[19:16], Instr[11:0]};

  cond_unit u_cond_unit (
    .clk         (clk),
    .rst         (reset),
    .i_cond      (Instr[31:28]),
    .i_alu_flags (ALUFlags),
    .i_exec      (w_exec),
    .i_s         (w_l),
    .i_cmd       (w_cmd),
    .o_cond_ex   (w_cond_ex)
  );

  always_comb begin
    w_exec_alu = c_ALU_ADD;
    w_is_mov   = 1'b0;
    w_no_write = 1'b0;
    case (w_cmd)
      c_CMD_ADD: w_exec_alu = c_ALU_ADD;
      c_CMD_SUB: w_exec_alu = c_ALU_SUB;
      c_CMD_CMP: begin
        w_exec_alu = c_ALU_SUB;
        w_no_write = 1'b1;
      end
      c_CMD_AND: w_exec_alu = c_ALU_AND;
      c_CMD_ORR: w_exec_alu = c_ALU_ORR;
      c_CMD_MOV: w_is_mov = 1'b1;
      default:   w_no_write = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (w_op)
            2'b01:   r_state <= S_MEMADR;
            2'b00:   r_state <= w_i ? S_EXECI : S_EXECR;
            2'b10:   r_state <= S_BRANCH;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= w_l ? S_MEMRD : S_MEMWR;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXECR,
        S_EXECI:  r_state <= S_ALUWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_we    = 1'b0;
    w_reg_we   = 1'b0;
    w_mem_we   = 1'b0;
    w_ir_we    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = c_SRCA_REG;
    ALUSrcB    = c_SRCB_RM;
    ResultSrc  = c_RES_ALUOUT;
    ALUControl = c_ALU_ADD;
    isShift    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_we   = 1'b1;
        w_pc_we   = 1'b1;
        ALUSrcA   = c_SRCA_PC;
        ALUSrcB   = c_SRCB_FOUR;
        ResultSrc = c_RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = c_SRCA_PC;
        ALUSrcB   = c_SRCB_FOUR;
        ResultSrc = c_RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = c_SRCB_IMM;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = c_RES_DATA;
        w_reg_we  = w_cond_ex;
        w_pc_we   = w_cond_ex & w_rd_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        w_mem_we = w_cond_ex;
      end
      S_EXECR: begin
        ALUControl = w_exec_alu;
        isShift    = w_is_mov;
      end
      S_EXECI: begin
        ALUSrcB    = c_SRCB_IMM;
        ALUControl = w_exec_alu;
        isShift    = w_is_mov;
      end
      S_ALUWB: begin
        w_reg_we = w_cond_ex & ~w_no_write;
        w_pc_we  = w_cond_ex & w_rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = c_SRCB_IMM;
        ResultSrc = c_RES_ALURESULT;
        w_pc_we   = w_cond_ex;
      end
      default: ;
    endcase
  end

  // Architectural write strobes are held off for the whole reset window.
  assign PCWrite  = w_pc_we  & ~reset;
  assign RegWrite = w_reg_we & ~reset;
  assign MemWrite = w_mem_we & ~reset;
  assign IRWrite  = w_ir_we  & ~reset;

  assign RegSrc = {(w_op == 2'b01) & ~w_l, (w_op == 2'b10)};
  assign ImmSrc = w_op;

endmodule

`default_nettype wire

// File: tb/tb_controller.sv
// ============================================================================
// Module   : tb_controller
// Brief    : Scoreboard bench for the multicycle control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_controller;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
  localparam int P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;

  typedef struct {
    logic [18:0] v;
    logic [18:0] m;
    int          ph;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, isShift;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;

  exp_t        exp_q[$];
  logic [3:0]  m_flags;
  int          n_checks = 0;
  int          n_fails  = 0;

  controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .isShift(isShift)
  );

  always #5 clk = ~clk;

  function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs of one cycle, with a mask for fields left open in that cycle.
  task automatic gen(input int ph, input logic [31:0] ins, input logic [3:0] fl,
                     input bit rst, output exp_t e);
    bit ce, rd15, mov, nowrite;
    logic [1:0] op, asa, asb, rs;
    logic [2:0] aluc;
    bit pcw, mw, rw, irw, adr, ish, c_adr, c_asa, c_asb, c_rs, c_alu;
    ce = cond_true(ins[31:28], fl);
    op = ins[27:26];
    rd15 = (ins[15:12] == 4'hF);
    mov = 0; nowrite = 0; aluc = 3'b000;
    case (ins[24:21])
      4'b0100: aluc = 3'b000;
      4'b0010: aluc = 3'b001;
      4'b1010: begin aluc = 3'b001; nowrite = 1; end
      4'b0000: aluc = 3'b010;
      4'b1100: aluc = 3'b011;
      4'b1101: mov = 1;
      default: nowrite = 1;
    endcase
    pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; ish = 0;
    asa = 0; asb = 0; rs = 0;
    c_adr = 0; c_asa = 0; c_asb = 0; c_rs = 0; c_alu = 0;
    case (ph)
      P_FETCH: begin
        irw = 1; pcw = 1; c_adr = 1; asa = 2'b01; asb = 2'b10; rs = 2'b10;
        c_asa = 1; c_asb = 1; c_rs = 1; c_alu = 1; aluc = 0;
      end
      P_DECODE: begin
        asa = 2'b01; asb = 2'b10; rs = 2'b10;
        c_asa = 1; c_asb = 1; c_rs = 1; c_alu = 1; aluc = 0;
      end
      P_MEMADR: begin asb = 2'b01; c_asa = 1; c_asb = 1; c_alu = 1; aluc = 0; end
      P_MEMRD:  begin adr = 1; c_adr = 1; c_rs = 1; end
      P_MEMWB:  begin rs = 2'b01; c_rs = 1; rw = ce; pcw = ce && rd15; end
      P_MEMWR:  begin adr = 1; c_adr = 1; c_rs = 1; mw = ce; end
      P_EXECR:  begin c_asa = 1; c_asb = 1; c_alu = 1; ish = mov; end
      P_EXECI:  begin asb = 2'b01; c_asa = 1; c_asb = 1; c_alu = 1; ish = mov; end
      P_ALUWB:  begin c_rs = 1; rw = ce && !nowrite; pcw = ce && rd15; end
      default: begin
        asb = 2'b01; rs = 2'b10; c_asa = 1; c_asb = 1; c_rs = 1; c_alu = 1;
        aluc = 0; pcw = ce;
      end
    endcase
    if (rst) begin pcw = 0; mw = 0; rw = 0; irw = 0; end
    e.v = {pcw, mw, rw, irw, adr, (op == 2'b01) && !ins[20], op == 2'b10,
           asa, asb, rs, op, aluc, ish};
    e.m = {4'b1111, c_adr, 2'b11, 1'b1, c_asa, {2{c_asb}}, {2{c_rs}}, 2'b11,
           {3{c_alu}}, c_alu};
    e.ph = ph;
    e.ins = ins;
  endtask

  // Phase list of one instruction straight from the instruction class.
  function automatic void phases(input logic [31:0] ins, output int ph[$]);
    ph = {P_FETCH, P_DECODE};
    case (ins[27:26])
      2'b01: if (ins[20]) ph = {ph, P_MEMADR, P_MEMRD, P_MEMWB};
             else         ph = {ph, P_MEMADR, P_MEMWR};
      2'b00: ph = {ph, ins[25] ? P_EXECI : P_EXECR, P_ALUWB};
      2'b10: ph = {ph, P_BRANCH};
      default: ;
    endcase
  endfunction

  function automatic logic [3:0] next_flags(input logic [31:0] ins, input logic [3:0] fl,
                                            input logic [3:0] af);
    logic [3:0] r;
    r = fl;
    if (ins[20] && cond_true(ins[31:28], fl)) begin
      case (ins[24:21])
        4'b0100, 4'b0010, 4'b1010: r = af;
        4'b0000, 4'b1100, 4'b1101: r = {af[3:2], fl[1:0]};
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af);
    int   ph[$];
    exp_t e;
    Instr = ins;
    ALUFlags = af;
    phases(ins, ph);
    foreach (ph[k]) begin
      gen(ph[k], ins, m_flags, 1'b0, e);
      exp_q.push_back(e);
      if (ph[k] == P_EXECR || ph[k] == P_EXECI) m_flags = next_flags(ins, m_flags, af);
    end
    repeat (ph.size()) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cond, cmd;
    logic [3:0] cmds[7];
    int k;
    cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1101, 4'b0000};
    cmds[6] = 4'($urandom);
    cond = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
    k = $urandom_range(0, 9);
    if (k <= 4) begin
      cmd = cmds[$urandom_range(0, 6)];
      return {cond, 2'b00, 1'($urandom), cmd, 1'($urandom), 4'($urandom), 4'($urandom),
              12'($urandom)};
    end else if (k <= 7) begin
      return {cond, 2'b01, 5'b01100, 1'($urandom), 4'($urandom), 4'($urandom),
              12'($urandom)};
    end else if (k == 8) begin
      return {cond, 4'b1010, 24'($urandom)};
    end
    return {cond, 2'b11, 26'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [18:0] got;
      e = exp_q.pop_front();
      got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, isShift};
      n_checks++;
      if (((got ^ e.v) & e.m) !== 19'd0) begin
        n_fails++;
        $display("FAIL cycle_outputs phase=%0d instr=%h got=%b expected=%b mask=%b",
                 e.ph, e.ins, got, e.v, e.m);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   ph[$];
    reset = 1'b1;
    Instr = 32'h0;
    ALUFlags = 4'h0;
    m_flags = 4'h0;
    @(posedge clk); #1;
    gen(P_FETCH, Instr, m_flags, 1'b1, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(32'hE0821003, 4'($urandom));
    run_instr(32'hE5921004, 4'($urandom));
    run_instr(32'hE5821004, 4'($urandom));
    run_instr(32'hE1510001, 4'b0100);
    run_instr(32'h0A000002, 4'($urandom));
    run_instr(32'h1A000002, 4'($urandom));
    run_instr(32'hE3A00005, 4'($urandom));
    run_instr(32'h13A00005, 4'($urandom));
    run_instr(32'hE351000F, 4'b1011);
    run_instr(32'hC2811004, 4'($urandom));
    run_instr(32'hB0811004, 4'($urandom));

    // Reset while an LDR sits in its memory-read cycle.
    Instr = 32'hE5921004;
    phases(Instr, ph);
    for (int k = 0; k < 3; k++) begin
      gen(ph[k], Instr, m_flags, 1'b0, e);
      exp_q.push_back(e);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    gen(P_MEMRD, Instr, m_flags, 1'b1, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = 4'h0;
    run_instr(32'h0A000002, 4'hF);
    run_instr(32'h1A000002, 4'hF);

    for (int n = 0; n < 300; n++) run_instr(rand_instr(), 4'($urandom));

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain leftover=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/controller.md
Name: controller

Overview:
Multicycle control unit that directly drives the multicycle ARM datapath. It decodes the latched instruction (Instr) and sequences the main state machine, producing every datapath select and enable plus MemWrite for the unified memory. It holds the NZCV flags register and evaluates condition codes to gate architectural writes. It supports data-processing (ADD/SUB/AND/ORR/CMP/MOV, register or immediate), LDR/STR (immediate offset, U=1), and B.

Parameters:
none (all encodings are fixed constants in the shared package)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Instr  in  32  instruction register contents from datapath
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  memory write strobe
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0=PC, 1=Result onto Adr
RegSrc  out  2  [0]=1 reads R15 on RA1; [1]=1 reads Rd on RA2
ALUSrcA  out  2  bit0: 0=A (or 0 when isShift), 1=PC; bit1 is always 0
ALUSrcB  out  2  00=shifted Rm, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  out  2  equals Instr[27:26]
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
isShift  out  1  forces SrcA to zero for MOV

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- State register (one-hot or binary, implementer's choice). States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Reset: on a clk edge with reset=1, state<=FETCH and flags<=4'b0000. While reset=1, PCWrite, RegWrite, MemWrite and IRWrite are forced 0. All other outputs follow the decode of the current state.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD, PCWrite=1 (unconditional). Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD (produces PC+8 for R15). Next state by Op=Instr[27:26]:
  - 01 -> MEMADR
  - 00 with I=Instr[25]=0 -> EXECR
  - 00 with I=1 -> EXECI
  - 10 -> BRANCH
  - 11 -> FETCH (unsupported; executes as NOP)
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Next state: MEMRD if L=Instr[20]=1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx -> FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondEx -> FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00 -> ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01 -> ALUWB.
- Opcode map in EXECR/EXECI, cmd=Instr[24:21]:
  - 0100 ADD
  - 0010 SUB
  - 1010 CMP (SUB, NoWrite)
  - 0000 AND
  - 1100 ORR
  - 1101 MOV (ADD, isShift=1)
  - any other cmd: ADD with NoWrite, flags untouched.
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite -> FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx -> FETCH.
- Rd=15 writeback: in MEMWB or ALUWB with Instr[15:12]=4'hF, PCWrite=CondEx as well.
- RegSrc: [0]=1 only for Op=10; [1]=1 only for Op=01 with L=0. Both are combinational from Instr in every state.
- Condition evaluation: CondEx is combinational from Instr[31:28] against the registered flags (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL). Cond=1111 evaluates false.
- Flags update: on the clk edge leaving EXECR/EXECI, flags<=ALUFlags only if S=Instr[20]=1 and CondEx. N,Z are always written; C,V are written only for ADD/SUB/CMP.
- Flags read/write order: a flags update and the next instruction's CondEx never overlap. The next CondEx is evaluated no earlier than its DECODE, so it always sees the updated flags.
- Cycle counts: branch 3, data-processing 4, STR 4, LDR 5.

Decomposition:
- Shared package: state enum, ALUControl encodings, ALUSrcB/ResultSrc encodings, cmd opcodes, cond codes.
- One sub-module: cond_unit, containing the flags register, CondEx logic and flag-write gating.

Test Plan:
- Reset held 2 cycles, then released with Instr=0xE0821003 (ADD R1,R2,R3) -> FETCH/DECODE/EXECR/ALUWB, RegWrite=1 only in cycle 4, PCWrite=1 only in cycle 1, back to FETCH.
- Instr=0xE5921004 (LDR R1,[R2,#4]) -> 5 cycles; ALUSrcB=01 in MEMADR; AdrSrc=1 in MEMRD; ResultSrc=01 with RegWrite=1 in MEMWB; MemWrite=0 throughout.
- Instr=0xE5821004 (STR) -> RegSrc=10; MemWrite=1 only in MEMWR; RegWrite never asserted.
- CMP R1,R1 (0xE1510001) with ALUFlags=0100 in EXECR -> flags=0100, RegWrite=0 in ALUWB. Then BEQ 0x0A000002 -> PCWrite=1 in BRANCH. Then BNE 0x1A000002 -> PCWrite=0 in BRANCH.
- MOV R0,#5 (0xE3A00005) -> isShift=1, ALUSrcB=01, ALUControl=000, RegWrite=1 in ALUWB. MOVNE with Z=1 -> RegWrite=0.
- Reset asserted mid-LDR (in MEMRD) -> next state FETCH, flags=0000, no RegWrite/MemWrite pulse issued.
